fpu_result_packer: RTL and testbench

- Downstream stage of the FPU pipeline: consumes the registered result/valid/exception stream and packs 32-bit results into 512-bit lines.
- Writes each completed line to HBM over the team's AXI-like single-beat request interface (req_valid/req_ready, addr, wr_en, wr_data).
- Supports flushing partial lines and reports line and exception counts for software.

---
 rtl/fpu_result_packer_if.sv | 28 ++
 rtl/fpu_result_packer.sv | 100 ++++++++++
 tb/tb_fpu_result_packer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_result_packer_if.sv
// rtl/fpu_result_packer_if.sv - result stream in, HBM single-beat write request out
interface fpu_result_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 512
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  in_exception;
    logic                  in_ready;
    logic                  flush;
    logic                  hbm_req_valid;
    logic                  hbm_req_ready;
    logic [31:0]           hbm_addr;
    logic                  hbm_wr_en;
    logic [LINE_WIDTH-1:0] hbm_wr_data;

    // Environment side: FPU result producer plus HBM responder
    modport master (
        output in_valid, in_result, in_exception, flush, hbm_req_ready,
        input  in_ready, hbm_req_valid, hbm_addr, hbm_wr_en, hbm_wr_data
    );

    // Packer side
    modport slave (
        input  in_valid, in_result, in_exception, flush, hbm_req_ready,
        output in_ready, hbm_req_valid, hbm_addr, hbm_wr_en, hbm_wr_data
    );
endinterface

// File: rtl/fpu_result_packer.sv
// rtl/fpu_result_packer.sv - packs 32-bit FPU results into 512-bit HBM line writes
module fpu_result_packer #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          LINE_WIDTH  = 512,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_LINES   = 256,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    fpu_result_packer_if.slave  bus,
    output logic [15:0]         lines_written,
    output logic [15:0]         exc_count,
    output logic                busy
);
    localparam int LANES  = LINE_WIDTH / DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [31:0]     LINE_BYTES = 32'(LINE_WIDTH / 8);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic {FILL, ISSUE} state_t;

    state_t                state;
    logic [LANE_W-1:0]     lane_cnt;
    logic [LINE_WIDTH-1:0] line_q;
    logic [IDX_W-1:0]      line_idx;
    logic                  in_ready_q;
    logic                  req_valid_q;
    logic                  accept;
    logic                  go_issue;
    logic [DATA_WIDTH-1:0] word;

    // Exception words are replaced by a quiet NaN so the line never carries garbage
    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        word     = bus.in_exception ? NAN_PATTERN[DATA_WIDTH-1:0] : bus.in_result;
        go_issue = (accept && (lane_cnt == LAST_LANE)) ||
                   (bus.flush && ((lane_cnt != '0) || accept));
    end

    // Packing FSM; request valid and ready come straight from registers so
    // hbm_req_valid has no combinational path from hbm_req_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            lane_cnt      <= '0;
            line_q        <= '0;
            line_idx      <= '0;
            lines_written <= '0;
            exc_count     <= '0;
            in_ready_q    <= 1'b1;
            req_valid_q   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        line_q[DATA_WIDTH*lane_cnt +: DATA_WIDTH] <= word;
                        lane_cnt <= lane_cnt + LANE_W'(1);
                        if (bus.in_exception && (exc_count != 16'hFFFF)) begin
                            exc_count <= exc_count + 16'd1;
                        end
                    end
                    if (go_issue) begin
                        state       <= ISSUE;
                        in_ready_q  <= 1'b0;
                        req_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    // flush is deliberately ignored here; the line is already closed
                    if (bus.hbm_req_ready) begin
                        state         <= FILL;
                        line_q        <= '0;
                        lane_cnt      <= '0;
                        line_idx      <= line_idx + IDX_W'(1);
                        lines_written <= lines_written + 16'd1;
                        in_ready_q    <= 1'b1;
                        req_valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Line address and status are pure functions of registered state
    always_comb begin
        bus.in_ready      = in_ready_q;
        bus.hbm_req_valid = req_valid_q;
        bus.hbm_wr_en     = req_valid_q;
        bus.hbm_wr_data   = line_q;
        bus.hbm_addr      = BASE_ADDR + 32'(line_idx) * LINE_BYTES;
        busy              = (lane_cnt != '0) || (state == ISSUE);
    end
endmodule

// File: tb/tb_fpu_result_packer.sv
// tb/tb_fpu_result_packer.sv - directed self-checking bench for fpu_result_packer
module tb_fpu_result_packer;
    logic clk;
    logic rst;
    logic [15:0] lines_written;
    logic [15:0] exc_count;
    logic busy;
    int tests;
    int fails;

    fpu_result_packer_if #(.DATA_WIDTH(32), .LINE_WIDTH(512)) bus ();

    fpu_result_packer #(
        .DATA_WIDTH(32), .LINE_WIDTH(512), .BASE_ADDR(32'h0000_0000),
        .NUM_LINES(256), .NAN_PATTERN(32'h7FC0_0000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lines_written(lines_written), .exc_count(exc_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] v, input logic exc, input logic fl);
        bus.in_valid     = 1'b1;
        bus.in_result    = v;
        bus.in_exception = exc;
        bus.flush        = fl;
        step();
        bus.in_valid     = 1'b0;
        bus.in_exception = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic handshake();
        bus.hbm_req_ready = 1'b1;
        step();
        bus.hbm_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.hbm_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.hbm_req_valid); end
        tests++; if (bus.hbm_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", bus.hbm_wr_en); end
        tests++; if (bus.hbm_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", bus.hbm_addr); end
        tests++; if (bus.hbm_wr_data !== 512'h0) begin fails++; $display("FAIL reset_data nonzero"); end
        tests++; if (lines_written !== 16'd0 || exc_count !== 16'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_status got lines=%0d exc=%0d busy=%b want 0 0 0", lines_written, exc_count, busy); end
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_line();
        logic [511:0] exp;
        int ready_bad;
        exp = '0;
        ready_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.in_ready !== 1'b1) ready_bad++;
            exp[32*i +: 32] = 32'h3F80_0000 + 32'(i);
            send_word(32'h3F80_0000 + 32'(i), 1'b0, 1'b0);
            if (i < 15 && bus.hbm_req_valid !== 1'b0) ready_bad++;
        end
        tests++; if (ready_bad != 0) begin fails++; $display("FAIL full_fill_ready got %0d bad cycles want 0", ready_bad); end
        tests++; if (bus.hbm_req_valid !== 1'b1 || bus.hbm_wr_en !== 1'b1) begin
            fails++; $display("FAIL full_valid got %b/%b want 1/1", bus.hbm_req_valid, bus.hbm_wr_en); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
        tests++; if (bus.hbm_addr !== 32'h0) begin fails++; $display("FAIL full_addr got %h want 0", bus.hbm_addr); end
        tests++; if (bus.hbm_wr_data !== exp) begin fails++; $display("FAIL full_data got %h want %h", bus.hbm_wr_data, exp); end
        handshake();
        tests++; if (bus.hbm_req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL full_after got valid=%b ready=%b want 0 1", bus.hbm_req_valid, bus.in_ready); end
        tests++; if (lines_written !== 16'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL full_lines got %0d busy=%b want 1 0", lines_written, busy); end
    endtask

    task automatic test_flush();
        logic [511:0] exp;
        exp = '0;
        for (int i = 0; i < 5; i++) begin
            exp[32*i +: 32] = 32'h4000_0000 + 32'(i);
            send_word(32'h4000_0000 + 32'(i), 1'b0, 1'b0);
        end
        tests++; if (busy !== 1'b1 || bus.hbm_req_valid !== 1'b0) begin
            fails++; $display("FAIL flush_partial got busy=%b valid=%b want 1 0", busy, bus.hbm_req_valid); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        tests++; if (bus.hbm_req_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %b want 1", bus.hbm_req_valid); end
        tests++; if (bus.hbm_addr !== 32'h40) begin fails++; $display("FAIL flush_addr got %h want 40", bus.hbm_addr); end
        tests++; if (bus.hbm_wr_data !== exp) begin fails++; $display("FAIL flush_data got %h want %h", bus.hbm_wr_data, exp); end
        handshake();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step(); step();
        tests++; if (bus.hbm_req_valid !== 1'b0 || lines_written !== 16'd2 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_empty got valid=%b lines=%0d busy=%b want 0 2 0", bus.hbm_req_valid, lines_written, busy); end
    endtask

    task automatic test_flush_accept();
        logic [511:0] exp;
        exp = '0;
        exp[31:0]  = 32'h1111_0000;
        exp[63:32] = 32'h1111_0001;
        exp[95:64] = 32'h1111_0002;
        send_word(32'h1111_0000, 1'b0, 1'b0);
        send_word(32'h1111_0001, 1'b0, 1'b0);
        send_word(32'h1111_0002, 1'b0, 1'b1);
        tests++; if (bus.hbm_req_valid !== 1'b1 || bus.hbm_addr !== 32'h80) begin
            fails++; $display("FAIL flush_acc_req got valid=%b addr=%h want 1 80", bus.hbm_req_valid, bus.hbm_addr); end
        tests++; if (bus.hbm_wr_data !== exp) begin fails++; $display("FAIL flush_acc_data got %h want %h", bus.hbm_wr_data, exp); end
        handshake();
    endtask

    task automatic test_stall();
        logic [511:0] exp;
        int bad;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[32*i +: 32] = 32'hA000_0000 + 32'(i);
            send_word(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        end
        // words and flushes offered while the request is pending must be ignored
        bus.in_valid = 1'b1; bus.in_result = 32'hDEAD_BEEF; bus.in_exception = 1'b1; bus.flush = 1'b1;
        for (int k = 0; k < 11; k++) begin
            bad = 0;
            if (bus.hbm_req_valid !== 1'b1) bad++;
            if (bus.hbm_addr !== 32'hC0) bad++;
            if (bus.hbm_wr_data !== exp) bad++;
            if (bus.in_ready !== 1'b0) bad++;
            tests++; if (bad != 0) begin
                fails++; $display("FAIL stall_hold cycle %0d valid=%b addr=%h ready=%b want 1 c0 0", k, bus.hbm_req_valid, bus.hbm_addr, bus.in_ready); end
            if (k < 10) step();
        end
        tests++; if (lines_written !== 16'd3) begin fails++; $display("FAIL stall_lines_pre got %0d want 3", lines_written); end
        handshake();
        bus.in_valid = 1'b0; bus.in_exception = 1'b0; bus.flush = 1'b0;
        step();
        tests++; if (lines_written !== 16'd4 || bus.hbm_req_valid !== 1'b0 || busy !== 1'b0 || exc_count !== 16'd0) begin
            fails++; $display("FAIL stall_after got lines=%0d valid=%b busy=%b exc=%0d want 4 0 0 0", lines_written, bus.hbm_req_valid, busy, exc_count); end
    endtask

    task automatic test_exception();
        logic [511:0] exp;
        logic e;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            e = (i == 3) || (i == 7);
            exp[32*i +: 32] = e ? 32'h7FC0_0000 : 32'h5000_0000 + 32'(i);
            send_word(32'h5000_0000 + 32'(i), e, 1'b0);
        end
        tests++; if (bus.hbm_addr !== 32'h100) begin fails++; $display("FAIL exc_addr got %h want 100", bus.hbm_addr); end
        tests++; if (bus.hbm_wr_data !== exp) begin fails++; $display("FAIL exc_data got %h want %h", bus.hbm_wr_data, exp); end
        tests++; if (exc_count !== 16'd2) begin fails++; $display("FAIL exc_count got %0d want 2", exc_count); end
        handshake();
    endtask

    task automatic test_rst_issue();
        logic [511:0] exp;
        for (int i = 0; i < 16; i++) send_word(32'h6000_0000 + 32'(i), 1'b0, 1'b0);
        tests++; if (bus.hbm_req_valid !== 1'b1) begin fails++; $display("FAIL rsti_pre_valid got %b want 1", bus.hbm_req_valid); end
        #1;
        rst = 1'b1;
        #1;
        tests++; if (bus.hbm_req_valid !== 1'b0 || bus.hbm_wr_en !== 1'b0 || bus.in_ready !== 1'b1 || lines_written !== 16'd0) begin
            fails++; $display("FAIL rsti_async got valid=%b wr_en=%b ready=%b lines=%0d want 0 0 1 0", bus.hbm_req_valid, bus.hbm_wr_en, bus.in_ready, lines_written); end
        step();
        rst = 1'b0;
        step();
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[32*i +: 32] = 32'h7000_0000 + 32'(i);
            send_word(32'h7000_0000 + 32'(i), 1'b0, 1'b0);
        end
        tests++; if (bus.hbm_addr !== 32'h0 || bus.hbm_wr_data !== exp) begin
            fails++; $display("FAIL rsti_next got addr=%h want 0 (or data wrong)", bus.hbm_addr); end
        handshake();
        tests++; if (lines_written !== 16'd1) begin fails++; $display("FAIL rsti_lines got %0d want 1", lines_written); end
    endtask

    task automatic test_wrap();
        logic [511:0] exp;
        logic [31:0] want_addr;
        int bad_addr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bad_addr = 0;
        for (int n = 0; n < 257; n++) begin
            exp = '0;
            for (int i = 0; i < 16; i++) begin
                exp[32*i +: 32] = (32'(n) << 8) | 32'(i);
                send_word((32'(n) << 8) | 32'(i), 1'b0, 1'b0);
            end
            want_addr = 32'(n % 256) * 32'd64;
            if (bus.hbm_req_valid !== 1'b1 || bus.hbm_addr !== want_addr) bad_addr++;
            if (n == 255) begin
                tests++; if (bus.hbm_addr !== 32'h3FC0 || bus.hbm_wr_data !== exp) begin
                    fails++; $display("FAIL wrap_line255 got addr=%h want 3fc0", bus.hbm_addr); end
            end
            if (n == 256) begin
                tests++; if (bus.hbm_addr !== 32'h0 || bus.hbm_wr_data !== exp) begin
                    fails++; $display("FAIL wrap_line256 got addr=%h want 0", bus.hbm_addr); end
            end
            handshake();
        end
        tests++; if (bad_addr != 0) begin fails++; $display("FAIL wrap_addr_seq got %0d bad lines want 0", bad_addr); end
        tests++; if (lines_written !== 16'd257) begin fails++; $display("FAIL wrap_lines got %0d want 257", lines_written); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_exception = 1'b0;
        bus.flush = 1'b0;
        bus.hbm_req_ready = 1'b0;
        test_reset();
        test_full_line();
        test_flush();
        test_flush_accept();
        test_stall();
        test_exception();
        test_rst_issue();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
